cam_sccb_config: RTL
====================

# cam_sccb_config

SCCB (I2C-like, write-only) configuration sequencer for the OV7670 camera. After reset, or on a `start` request, it walks a register ROM of {register, value} pairs and issues one 3-phase SCCB write per entry (ID 0x42, register, value). It sits beside the capture/VGA datapath, runs from the 25 MHz domain, and puts the sensor in the RGB565 QVGA mode that the capture block expects.

## Interface
- `QDIV`, 62: clk cycles per SCCB quarter-bit (25 MHz / (4 × 100 kHz)).
- `PWRUP_CYC`, 25000: wait after reset before the first transaction (1 ms).
- `RST_WAIT_CYC`, 25000: wait after a soft-reset write (reg 0x12, value bit7 = 1).
- `AUTO_START`, 1: 1 = start the sequence automatically after reset.
- `DEV_ID`, 8'h42: SCCB write ID.
- `clk`  in  1  system clock, 25 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; restarts the sequence from ROM index 0.
- `busy`  out  1  high while the sequence runs, including the power-up wait.
- `done`  out  1  level; high after the end marker, cleared by `start` or reset.
- `reg_idx`  out  8  index of the ROM entry currently being sent.
- `sioc`  out  1  SCCB clock, push-pull.
- `siod_o`  out  1  SCCB data value.
- `siod_oe`  out  1  data drive enable; the top level tristates SIOD when this is 0.
- Reset is asynchronous and active-low. There is one clock, `clk`; the reset port is named `rst`.

## Operation
- Reset values: `sioc`=1, `siod_o`=1, `siod_oe`=0, `busy`=0, `done`=0, `reg_idx`=0, state IDLE.
- States: IDLE, PWRUP, FETCH, START, BITS, STOP, GAP, RSTWAIT, DONE.
- IDLE: when `AUTO_START`=1, go to PWRUP on the first cycle after reset deassertion. `start` also goes to PWRUP.
- PWRUP: count `PWRUP_CYC` cycles, then go to FETCH.
- FETCH: read ROM[`reg_idx`] (1-cycle registered read) and load the 27-bit shift word: ID, Z, reg, Z, val, Z.
  - Z marks a don't-care bit: `siod_oe`=0 for that bit. No ACK is checked.
  - Entry 16'hFFFF is the end marker: go to DONE and send nothing.
- START: 2 quarters.
  - Q0: `siod_oe`=1, `siod_o`=0, `sioc`=1.
  - Q1: `sioc`=0.
- BITS: 27 bits, MSB first, 4 quarters each.
  - Q0: `sioc`=0; data changes at the start of Q0.
  - Q1: `sioc`=0.
  - Q2, Q3: `sioc`=1.
- STOP: 3 quarters.
  - Q0: `sioc`=0, SIOD driven 0.
  - Q1: `sioc`=1.
  - Q2: `siod_oe`=0 (line released high).
- GAP: 4 idle quarters. Then:
  - If the entry just sent was reg 0x12 with val[7]=1, go to RSTWAIT (`RST_WAIT_CYC`).
  - Otherwise increment `reg_idx` and go to FETCH. RSTWAIT also increments `reg_idx` and goes to FETCH.
- DONE: `busy`=0, `done`=1, bus idle. `start` restarts the sequence with `reg_idx`=0.
- `start` while `busy`=1 is ignored. A `start` arriving in the same cycle the end marker is fetched is also ignored.
- `reg_idx` wraps 255→0 if there is no end marker. The ROM must always contain one; the bench asserts this.
- Reset asserted mid-transaction: immediate release (`sioc`=1, `siod_oe`=0). The sequence restarts only via AUTO_START or `start`.

## Timing
- One transaction, FETCH entry to next FETCH entry: 1 + 117·`QDIV` cycles. With the default `QDIV` this is 7255 cycles, about 290 µs.
- `sioc` frequency = clk / (4·`QDIV`).
- Data is stable through the full `sioc`-high half (2·`QDIV` cycles).
- The quarter counter is 0..`QDIV`-1, and all outputs change on the counter wrap only.
- Outputs are registered: no combinational path from `start` to any output.
- `busy` rises 1 cycle after `start`.
- `done` rises 2 cycles after the end marker is presented at the ROM address.

## Structure
- Package `cam_cfg_pkg`: `DEV_ID`, end marker 16'hFFFF, soft-reset register 0x12, state encoding, and the 27-bit frame-format constants.
- Sub-module `cam_reg_rom`: synchronous ROM, 8-bit address → 16-bit {reg, val}.
  - Contents: COM7 reset, then COM7=0x14 (QVGA RGB), COM15=0xD0 (RGB565), CLKRC, TSLB, then the end marker.
- Top module: FSM, quarter counter, bit counter, shift register, wait counter.

## Test plan
- Reset then AUTO_START, `QDIV`=2, `PWRUP_CYC`=10: first SIOD fall (with `sioc` high) at cycle 11 ±1. Decoded bytes are 0x42, 0x12, 0x80.
- Bit-level check: an SCCB monitor samples SIOD on the `sioc` rising edge. Every ROM entry decodes as ID/reg/val, and each Z bit has `siod_oe`=0.
- Soft-reset entry (0x12/0x80), `RST_WAIT_CYC`=50: the gap before the next START is 4·`QDIV` + 50 cycles.
  - A normal entry gives a gap of exactly 4·`QDIV` cycles.
- 3-entry ROM plus end marker: `done`=1 and `busy`=0 after 3 transactions. `sioc` and `siod_oe` stay idle afterward. `start` in DONE reruns the sequence from `reg_idx`=0.
- `start` pulsed mid-transaction: no effect. Transaction count and data are unchanged.
- `rst` low in the middle of BITS: `sioc`=1 and `siod_oe`=0 in the same cycle (asynchronous). After release the sequence restarts at index 0 after `PWRUP_CYC`.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared constants, state encoding and SCCB frame helpers for the OV7670 config sequencer.
package cam_cfg_pkg;

    localparam logic [7:0]  SCCB_WR_ID = 8'h42;
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [7:0]  REG_COM7   = 8'h12;

    localparam int FRAME_BITS = 27;
    localparam int START_Q    = 2;
    localparam int BIT_Q      = 4;
    localparam int STOP_Q     = 3;
    localparam int GAP_Q      = 4;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_START, S_BITS, S_STOP, S_GAP, S_RSTWAIT, S_DONE
    } state_t;

    // 3-phase write: ID, Z, reg, Z, val, Z. Z positions carry 1 but are not driven.
    function automatic logic [26:0] frame_word(input logic [7:0] id, input logic [15:0] ent);
        return {id, 1'b1, ent[15:8], 1'b1, ent[7:0], 1'b1};
    endfunction

    function automatic logic is_z_bit(input logic [4:0] bidx);
        return (bidx == 5'd8) || (bidx == 5'd17) || (bidx == 5'd26);
    endfunction

endpackage

// File: rtl/cam_reg_rom.sv
// Synchronous register ROM: address -> {reg, val}; unused addresses read as the end marker.
module cam_reg_rom
    import cam_cfg_pkg::*;
(
    input  logic        clk,
    input  logic [7:0]  addr,
    output logic [15:0] data
);

    logic [15:0] rom_q;

    always_ff @(posedge clk) begin
        case (addr)
            8'd0:    rom_q <= 16'h1280;   // COM7 soft reset
            8'd1:    rom_q <= 16'h1214;   // COM7: QVGA, RGB
            8'd2:    rom_q <= 16'h40D0;   // COM15: RGB565, full range
            8'd3:    rom_q <= 16'h1101;   // CLKRC
            8'd4:    rom_q <= 16'h3A04;   // TSLB
            default: rom_q <= END_MARK;
        endcase
    end

    assign data = rom_q;

endmodule

// File: rtl/cam_sccb_config.sv
// OV7670 SCCB write sequencer: walks the register ROM and bit-bangs one 3-phase write per entry.
module cam_sccb_config
    import cam_cfg_pkg::*;
#(
    parameter int         QDIV         = 62,
    parameter int         PWRUP_CYC    = 25000,
    parameter int         RST_WAIT_CYC = 25000,
    parameter bit         AUTO_START   = 1'b1,
    parameter logic [7:0] DEV_ID       = SCCB_WR_ID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] reg_idx,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe
);

    localparam int WAIT_MAX = (PWRUP_CYC > RST_WAIT_CYC) ? PWRUP_CYC : RST_WAIT_CYC;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int QW       = (QDIV > 1) ? $clog2(QDIV) : 1;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      qph_q, qph_d;
    logic [4:0]      bcnt_q, bcnt_d;
    logic [26:0]     sh_q, sh_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [7:0]      idx_q, idx_d;
    logic            soft_q, soft_d;
    logic            sioc_d, siod_d, oe_d, busy_d, done_d;
    logic            qwrap;
    logic [15:0]     rom_data;

    // Address from the next index so the entry is already registered in FETCH.
    cam_reg_rom u_rom (.clk(clk), .addr(idx_d), .data(rom_data));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            qph_q   <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            soft_q  <= 1'b0;
            sioc    <= 1'b1;
            siod_o  <= 1'b1;
            siod_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qph_q   <= qph_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            soft_q  <= soft_d;
            sioc    <= sioc_d;
            siod_o  <= siod_d;
            siod_oe <= oe_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qph_d   = qph_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        soft_d  = soft_q;
        qwrap   = (qcnt_q == QW'(QDIV - 1));

        if (state_q inside {S_START, S_BITS, S_STOP, S_GAP}) begin
            qcnt_d = qwrap ? '0 : qcnt_q + 1'b1;
            if (qwrap) qph_d = qph_q + 2'd1;
        end

        case (state_q)
            S_IDLE: if (AUTO_START || start) begin
                state_d = S_PWRUP;
                wcnt_d  = '0;
            end
            S_PWRUP: begin
                if (wcnt_q == WW'(PWRUP_CYC - 1)) state_d = S_FETCH;
                else                              wcnt_d  = wcnt_q + 1'b1;
            end
            S_FETCH: begin
                if (rom_data == END_MARK) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_START;
                    sh_d    = frame_word(DEV_ID, rom_data);
                    soft_d  = (rom_data[15:8] == REG_COM7) && rom_data[7];
                    qcnt_d  = '0;
                    qph_d   = '0;
                    bcnt_d  = '0;
                end
            end
            S_START: if (qwrap && qph_q == 2'(START_Q - 1)) begin
                state_d = S_BITS;
                qph_d   = '0;
            end
            S_BITS: if (qwrap && qph_q == 2'(BIT_Q - 1)) begin
                qph_d = '0;
                if (bcnt_q == 5'(FRAME_BITS - 1)) begin
                    state_d = S_STOP;
                end else begin
                    bcnt_d = bcnt_q + 5'd1;
                    sh_d   = sh_q << 1;
                end
            end
            S_STOP: if (qwrap && qph_q == 2'(STOP_Q - 1)) begin
                state_d = S_GAP;
                qph_d   = '0;
            end
            S_GAP: if (qwrap && qph_q == 2'(GAP_Q - 1)) begin
                qph_d = '0;
                if (soft_q) begin
                    state_d = S_RSTWAIT;
                    wcnt_d  = '0;
                end else begin
                    state_d = S_FETCH;
                    idx_d   = idx_q + 8'd1;
                end
            end
            S_RSTWAIT: begin
                if (wcnt_q == WW'(RST_WAIT_CYC - 1)) begin
                    state_d = S_FETCH;
                    idx_d   = idx_q + 8'd1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DONE: if (start) begin
                state_d = S_PWRUP;
                idx_d   = '0;
                wcnt_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus levels for the quarter being entered; they only move on a wrap or out of FETCH.
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            S_START: begin
                oe_d   = 1'b1;
                siod_d = 1'b0;
                sioc_d = (qph_d == 2'd0);
            end
            S_BITS: begin
                sioc_d = qph_d[1];
                siod_d = sh_d[26];
                oe_d   = !is_z_bit(bcnt_d);
            end
            S_STOP: if (qph_d != 2'd2) begin
                oe_d   = 1'b1;
                siod_d = 1'b0;
                sioc_d = (qph_d == 2'd1);
            end
            default: ;
        endcase
        busy_d = !(state_d inside {S_IDLE, S_DONE});
        done_d = (state_d == S_DONE);
    end

    assign reg_idx = idx_q;

endmodule
